// File: rtl/execute_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks outstanding writes per architectural register, stalls issue on
// read-after-write or counter-saturation hazards, and blocks issue for a
// fixed drain window after a branch-misprediction flush.
module execute_scoreboard #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic [REG_ADDR_W-1:0]   issue_rs1,
    input  logic [REG_ADDR_W-1:0]   issue_rs2,
    input  logic                    issue_uses_rs1,
    input  logic                    issue_uses_rs2,
    input  logic [REG_ADDR_W-1:0]   issue_rd,
    input  logic                    issue_writes_rd,
    output logic                    issue_ready,
    input  logic                    retire_valid,
    input  logic [REG_ADDR_W-1:0]   retire_rd,
    input  logic                    flush_valid,
    input  logic [1:0]              kill_valid,
    input  logic [2*REG_ADDR_W-1:0] kill_rd,
    output logic [NUM_REGS-1:0]     busy_mask,
    output logic [31:0]             stall_count,
    output logic                    scoreboard_error
);

    localparam int unsigned CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned DRAIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]     count_q [NUM_REGS];
    logic [CNT_W-1:0]     count_d [NUM_REGS];
    logic [31:0]          stall_count_q, stall_count_d;
    logic                 err_q, err_d;
    logic                 hazard;
    logic                 issue_accept;
    int                   net;

    // Hazard detection against registered counts; register 0 is never busy.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (count_q[r] != '0) begin
                if (issue_uses_rs1 && issue_rs1 == REG_ADDR_W'(r)) hazard = 1'b1;
                if (issue_uses_rs2 && issue_rs2 == REG_ADDR_W'(r)) hazard = 1'b1;
            end
            if (issue_writes_rd && issue_rd == REG_ADDR_W'(r) &&
                count_q[r] == CNT_W'(MAX_INFLIGHT)) hazard = 1'b1;
        end
    end

    // Issue state machine: next state, drain counter and issue handshake.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        issue_ready = !flush_valid && (state_q != ST_FLUSH) && !hazard;
        if (flush_valid) begin
            state_d = ST_FLUSH;
            drain_d = DRAIN_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                ST_RUN:   if (issue_valid && hazard) state_d = ST_STALL;
                ST_STALL: if (!hazard || !issue_valid) state_d = ST_RUN;
                ST_FLUSH: begin
                    if (drain_q == '0) state_d = ST_RUN;
                    else               drain_d = drain_q - 1'b1;
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    assign issue_accept = issue_valid && issue_ready;

    // Per-register net update: the issue increment and all decrements are
    // summed first so that a same-cycle issue and retire cancel out; a net
    // result below zero clamps to zero and flags an underflow.
    always_comb begin
        err_d      = err_q;
        net        = 0;
        count_d[0] = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            net = int'(count_q[r]);
            if (issue_accept && issue_writes_rd && issue_rd == REG_ADDR_W'(r)) net = net + 1;
            if (retire_valid && retire_rd == REG_ADDR_W'(r)) net = net - 1;
            if (kill_valid[0] && kill_rd[REG_ADDR_W-1:0] == REG_ADDR_W'(r)) net = net - 1;
            if (kill_valid[1] && kill_rd[2*REG_ADDR_W-1:REG_ADDR_W] == REG_ADDR_W'(r)) net = net - 1;
            if (net < 0) begin
                count_d[r] = '0;
                err_d      = 1'b1;
            end else begin
                count_d[r] = CNT_W'(net);
            end
        end
    end

    // Saturating count of cycles where decode offered an instruction that was refused.
    always_comb begin
        stall_count_d = stall_count_q;
        if (issue_valid && !issue_ready && stall_count_q != '1)
            stall_count_d = stall_count_q + 32'd1;
    end

    // Busy view derived from the registered counters.
    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++)
            busy_mask[r] = (count_q[r] != '0);
    end

    assign stall_count      = stall_count_q;
    assign scoreboard_error = err_q;

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            drain_q       <= '0;
            stall_count_q <= '0;
            err_q         <= 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            stall_count_q <= stall_count_d;
            err_q         <= err_d;
            for (int unsigned r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
        end
    end

endmodule

// File: tb/tb_execute_scoreboard.sv
// Self-checking bench for execute_scoreboard: directed scenarios plus a
// randomized phase, all checked against a per-register counter model.
module tb_execute_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int MI = 3;
    localparam int FC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
    logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
    logic            issue_ready;
    logic            retire_valid;
    logic [AW-1:0]   retire_rd;
    logic            flush_valid;
    logic [1:0]      kill_valid;
    logic [2*AW-1:0] kill_rd;
    logic [NR-1:0]   busy_mask;
    logic [31:0]     stall_count;
    logic            scoreboard_error;

    always #5 clk = ~clk;

    execute_scoreboard #(
        .NUM_REGS(NR), .REG_ADDR_W(AW), .MAX_INFLIGHT(MI), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd),
        .issue_ready(issue_ready),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .flush_valid(flush_valid), .kill_valid(kill_valid), .kill_rd(kill_rd),
        .busy_mask(busy_mask), .stall_count(stall_count),
        .scoreboard_error(scoreboard_error)
    );

    int  total = 0;
    int  bad   = 0;
    int  m_cnt [NR];
    bit  m_err;
    int  m_stall;
    int  cyc;
    int  last_flush;
    bit  exp_ready;

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_err      = 1'b0;
        m_stall    = 0;
        last_flush = -100;
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        if (issue_uses_rs1 && issue_rs1 != 0 && m_cnt[issue_rs1] != 0) h = 1'b1;
        if (issue_uses_rs2 && issue_rs2 != 0 && m_cnt[issue_rs2] != 0) h = 1'b1;
        if (issue_writes_rd && issue_rd != 0 && m_cnt[issue_rd] == MI) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < NR; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        retire_valid = 0; retire_rd = '0;
        flush_valid = 0; kill_valid = '0; kill_rd = '0;
    endtask

    task automatic set_issue(input bit v, input int rs1, input bit u1, input int rs2,
                             input bit u2, input int rd, input bit w);
        issue_valid = v;
        issue_rs1 = AW'(rs1); issue_uses_rs1 = u1;
        issue_rs2 = AW'(rs2); issue_uses_rs2 = u2;
        issue_rd = AW'(rd);   issue_writes_rd = w;
    endtask

    // Check one cycle against the model, then advance model and DUT by one edge.
    task automatic tick();
        int d [NR];
        int v;
        #2;
        exp_ready = !flush_valid && (cyc > last_flush + FC) && !m_hazard();
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("busy_mask", busy_mask, m_busy());
        chk("stall_count", stall_count, 32'(m_stall));
        chk("scoreboard_error", 32'(scoreboard_error), 32'(m_err));
        @(posedge clk);
        for (int r = 0; r < NR; r++) d[r] = 0;
        if (issue_valid && exp_ready && issue_writes_rd) d[issue_rd]++;
        if (retire_valid) d[retire_rd]--;
        if (kill_valid[0]) d[kill_rd[AW-1:0]]--;
        if (kill_valid[1]) d[kill_rd[2*AW-1:AW]]--;
        for (int r = 1; r < NR; r++) begin
            v = m_cnt[r] + d[r];
            if (v < 0) begin v = 0; m_err = 1'b1; end
            m_cnt[r] = v;
        end
        if (issue_valid && !exp_ready) m_stall++;
        if (flush_valid) last_flush = cyc;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int pd [NR];
        int k, rr;
        cyc = 0;
        model_reset();
        idle();
        rst_n = 0;
        #1;
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_stall", stall_count, 32'h0);
        chk("rst_err", 32'(scoreboard_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // RAW: producer rd=5 then consumer reading rs1=5
        set_issue(1, 0, 0, 0, 0, 5, 1);
        tick();
        chk("t1_busy", busy_mask, 32'h20);
        set_issue(1, 5, 1, 0, 0, 6, 0);
        #1 chk("t1_stalled", 32'(issue_ready), 32'd0);
        tick(); tick(); tick();
        retire_valid = 1; retire_rd = 5'd5;
        tick();
        retire_valid = 0;
        #1 chk("t1_ready_after_retire", 32'(issue_ready), 32'd1);
        tick();
        chk("t1_stall_count", stall_count, 32'd4);

        // Saturation on rd=7
        set_issue(1, 0, 0, 0, 0, 7, 1);
        tick(); tick(); tick();
        #1 chk("t2_full", 32'(issue_ready), 32'd0);
        retire_valid = 1; retire_rd = 5'd7;
        tick();
        retire_valid = 0;
        tick();
        idle();
        retire_valid = 1; retire_rd = 5'd7;
        tick(); tick(); tick();
        idle();

        // Same-cycle issue and retire to rd=9
        set_issue(1, 0, 0, 0, 0, 9, 1);
        tick();
        retire_valid = 1; retire_rd = 5'd9;
        tick();
        idle();
        chk("t3_busy9", 32'(busy_mask[9]), 32'd1);
        retire_valid = 1; retire_rd = 5'd9;
        tick();
        idle();

        // Flush with kills of rd=3 and rd=4, then an extended window
        set_issue(1, 0, 0, 0, 0, 3, 1); tick();
        set_issue(1, 0, 0, 0, 0, 4, 1); tick();
        set_issue(1, 0, 0, 0, 0, 10, 1);
        flush_valid = 1; kill_valid = 2'b11; kill_rd = {5'd3, 5'd4};
        #1 chk("t4_flush_comb", 32'(issue_ready), 32'd0);
        tick();
        flush_valid = 0; kill_valid = '0;
        chk("t4_killed", busy_mask & 32'h18, 32'h0);
        tick(); tick();
        #1 chk("t4_reopen", 32'(issue_ready), 32'd1);
        idle();
        tick();
        flush_valid = 1; tick();
        flush_valid = 0; tick();
        flush_valid = 1; tick();
        flush_valid = 0;
        set_issue(1, 0, 0, 0, 0, 11, 0);
        tick(); tick(); tick();
        idle();

        // Randomized traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NR; r++) pd[r] = 0;
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 1));
            rr = $urandom_range(1, 7);
            retire_valid = (m_cnt[rr] > 0) && ($urandom_range(0, 1) == 1);
            retire_rd = AW'(rr);
            if (retire_valid) pd[rr]++;
            flush_valid = ($urandom_range(0, 19) == 0);
            kill_valid = '0;
            kill_rd = '0;
            if (flush_valid) begin
                for (int s = 0; s < 2; s++) begin
                    k = $urandom_range(1, 7);
                    if (m_cnt[k] - pd[k] > 0) begin
                        pd[k]++;
                        kill_valid[s] = 1'b1;
                        if (s == 0) kill_rd[AW-1:0] = AW'(k);
                        else        kill_rd[2*AW-1:AW] = AW'(k);
                    end
                end
            end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Underflow on an idle register, error is sticky
        retire_valid = 1; retire_rd = 5'd12;
        tick();
        idle();
        chk("t5_err_set", 32'(scoreboard_error), 32'd1);
        tick(); tick();
        chk("t5_err_sticky", 32'(scoreboard_error), 32'd1);

        // Register 0 never causes a hazard or becomes busy
        set_issue(1, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_r0_ready", 32'(issue_ready), 32'd1);
            tick();
        end
        chk("t5_r0_busy", 32'(busy_mask[0]), 32'd0);
        idle();

        // Fill every register, stall, then reset mid-stall
        for (int r = 1; r < NR; r++) begin
            if (m_cnt[r] < MI) begin
                set_issue(1, 0, 0, 0, 0, r, 1);
                tick();
            end
        end
        set_issue(1, 5, 1, 0, 0, 0, 0);
        chk("t6_all_busy", busy_mask, 32'hFFFF_FFFE);
        tick();
        #3 rst_n = 0;
        #1;
        chk("t6_rst_busy", busy_mask, 32'h0);
        chk("t6_rst_stall", stall_count, 32'h0);
        chk("t6_rst_err", 32'(scoreboard_error), 32'd0);
        chk("t6_rst_ready", 32'(issue_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick(); tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_scoreboard.md
# execute_scoreboard

Register-hazard scoreboard and issue controller sitting between the decode stage and the execute stage. It tracks, per architectural register, how many issued instructions still have a write to it outstanding. It stalls decode-to-execute issue on read-after-write or counter-saturation hazards and holds issue off for a fixed drain window after a branch-misprediction flush. Writeback retires entries; the flush path cancels the entries of killed instructions.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- REG_ADDR_W, 5, register index width.
- MAX_INFLIGHT, 3, maximum outstanding writes per register; per-register counter width is $clog2(MAX_INFLIGHT+1).
- FLUSH_CYCLES, 2, number of cycles issue is blocked after a flush; must be ≥1.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- issue_valid  in  1  decode presents an instruction for issue.
- issue_rs1, issue_rs2  in  REG_ADDR_W  source register indices.
- issue_uses_rs1, issue_uses_rs2  in  1  the instruction reads that source.
- issue_rd  in  REG_ADDR_W  destination register index.
- issue_writes_rd  in  1  the instruction writes rd.
- issue_ready  out  1  combinational; the instruction is accepted when issue_valid && issue_ready.
- retire_valid  in  1  writeback completed a write.
- retire_rd  in  REG_ADDR_W  register written.
- flush_valid  in  1  branch misprediction from execute; single-cycle pulse.
- kill_valid  in  2  per-slot cancellation of an issued-but-not-retired write (slot 0 = execute, slot 1 = decode output).
- kill_rd  in  2×REG_ADDR_W  destination register of each killed slot.
- busy_mask  out  NUM_REGS  registered; bit r = count[r] != 0; bit 0 is always 0.
- stall_count  out  32  registered; saturating count of stalled cycles.
- scoreboard_error  out  1  registered, sticky; set on a retire or kill underflow.

## Operation
- Per-register counter count[r] for r = 1..NUM_REGS-1. Net update per cycle: +1 on an accepted issue with issue_writes_rd, −1 on each retire, −1 on each kill slot, all summed. An accepted issue and a retire to the same rd in the same cycle leave the counter unchanged.
- Any update addressing r = 0 is ignored.
- Underflow: if a decrement would take a counter below 0, the counter stays at 0 and scoreboard_error is set. scoreboard_error clears only on reset.
- Hazard = (uses_rs1 && rs1≠0 && busy[rs1]) || (uses_rs2 && rs2≠0 && busy[rs2]) || (writes_rd && rd≠0 && count[rd]==MAX_INFLIGHT).
- Hazard evaluation uses registered counts only. A same-cycle retire does not clear a hazard.
- State machine:
  - RUN: if issue_valid && hazard, go to STALL.
  - STALL: if !hazard || !issue_valid, go to RUN.
  - flush_valid from any state goes to FLUSH and loads drain_cnt = FLUSH_CYCLES−1.
  - FLUSH: decrement drain_cnt; at 0, go to RUN. A flush_valid during FLUSH reloads drain_cnt.
- issue_ready = !flush_valid && state≠FLUSH && !hazard.
- Kills and retires are processed in every state, including FLUSH. Issue is never accepted in the cycle flush_valid is high.
- stall_count increments when issue_valid && !issue_ready, and saturates at 0xFFFF_FFFF.

## Timing
- Reset (rst_n low, asynchronous):
  - all counters 0, busy_mask 0, state RUN, drain_cnt 0, stall_count 0, scoreboard_error 0.
  - issue_ready is therefore 1 while in reset unless flush_valid is high.
- Accepting an issue at edge N makes busy_mask[rd] visible after edge N, in cycle N+1. A dependent instruction presented in cycle N+1 sees issue_ready=0.
- A retire at edge N clears busy (if count reaches 0) after edge N. The dependent instruction is accepted in cycle N+1, so the minimum stall after the producer's retire is 1 cycle.
- A flush_valid pulse in cycle N drops issue_ready in cycle N combinationally. issue_ready stays low for cycles N+1..N+FLUSH_CYCLES and may return in cycle N+FLUSH_CYCLES+1.
- Asserting rst_n low mid-stall or mid-flush returns to RUN immediately. All outstanding entries are discarded.

## Test plan
- Reset, then issue rd=5, followed next cycle by an instruction reading rs1=5 → issue_ready=0 and busy_mask=0x20. Retire rd=5 → issue_ready=1 one cycle later; stall_count equals the number of stalled cycles.
- Three accepted issues to rd=7 with no retire → count=3. A fourth issue to rd=7 → issue_ready=0. Retire rd=7 → accepted the next cycle.
- Issue and retire rd=9 in the same cycle with count[9]=1 → count stays 1 and busy_mask[9]=1.
- flush_valid pulse with kill_valid=2'b11, kill_rd={3,4}, both counts at 1 → busy_mask bits 3 and 4 clear. issue_ready is low for 1+FLUSH_CYCLES=3 cycles. A second flush during FLUSH extends the window.
- Retire rd=12 with count[12]=0 → scoreboard_error=1 and stays 1. Issue rd=0 or a read of rs1=0 → never stalls, and busy_mask[0]=0.
- rst_n asserted low during STALL with busy_mask=0xFFFF_FFFE → all outputs at reset values immediately; issue_ready=1.
